pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the five-stage pipeline. Drives the `load` enable of the PC register and of every inter-stage N_bit_register (IF/ID, ID/EX, EX/MEM, MEM/WB). Also drives bubble/flush requests.
- Arbitrates the single-ported unified memory between instruction fetch (IF) and data access (MEM).
- Handles load-use stalls, taken-branch flushes, multi-cycle memory waits and halt. Keeps saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: register load enables, bubbles/flushes, memory port
// arbitration between fetch and MEM, halt, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_load,
  output logic             ifid_load,
  output logic             idex_load,
  output logic             exmem_load,
  output logic             memwb_load,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_sel_data,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_e;

  localparam logic [CNT_W-1:0] ONE = 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;
  logic             flush_ev;

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    state_d      = state_q;
    pc_load      = 1'b0;
    ifid_load    = 1'b0;
    idex_load    = 1'b0;
    exmem_load   = 1'b0;
    memwb_load   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    mem_sel_data = 1'b0;
    halted       = 1'b0;
    flush_ev     = 1'b0;
    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (state_q == MEM_WAIT && !mem_ready) begin
          state_d = MEM_WAIT;
        end else if (halt_req) begin
          memwb_load = 1'b1;
          state_d    = HALTED;
        end else if (mem_req && !mem_ready) begin
          mem_sel_data = 1'b1;
          state_d      = MEM_WAIT;
        end else if (ex_branch_taken) begin
          pc_load      = 1'b1;
          ifid_load    = 1'b1;
          idex_load    = 1'b1;
          exmem_load   = 1'b1;
          memwb_load   = 1'b1;
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          mem_sel_data = mem_req;
          flush_ev     = 1'b1;
          state_d      = RUN;
        end else if (load_use) begin
          idex_load    = 1'b1;
          idex_flush   = 1'b1;
          exmem_load   = 1'b1;
          memwb_load   = 1'b1;
          mem_sel_data = mem_req;
          state_d      = RUN;
        end else if (mem_req) begin
          // Data access steals the port: the fetch slot becomes a bubble
          ifid_load    = 1'b1;
          ifid_flush   = 1'b1;
          idex_load    = 1'b1;
          exmem_load   = 1'b1;
          memwb_load   = 1'b1;
          mem_sel_data = 1'b1;
          state_d      = RUN;
        end else begin
          pc_load    = 1'b1;
          ifid_load  = 1'b1;
          idex_load  = 1'b1;
          exmem_load = 1'b1;
          memwb_load = 1'b1;
          state_d    = RUN;
        end
        if (state_q == MEM_WAIT) mem_sel_data = 1'b1;
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      pc_load      = 1'b0;
      ifid_load    = 1'b0;
      idex_load    = 1'b0;
      exmem_load   = 1'b0;
      memwb_load   = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      mem_sel_data = 1'b0;
      halted       = 1'b0;
      flush_ev     = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != HALTED && !pc_load && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + ONE;
    if (flush_ev && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table plus hand sequences
// for memory wait, halt, async reset and counter saturation.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       ex_memread = 0, ex_branch_taken = 0;
  logic       mem_req = 0, mem_ready = 0, halt_req = 0;
  logic       pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic       ifid_flush, idex_flush, mem_sel_data, halted;
  logic [31:0] stall_cnt, flush_cnt;
  logic       s_pc, s_ifid, s_idex, s_exmem, s_memwb;
  logic       s_iff, s_idf, s_sel, s_halted;
  logic [2:0] s_stall, s_flush;

  int n_cmp = 0;
  int n_err = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
    .exmem_load(exmem_load), .memwb_load(memwb_load),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_sel_data(mem_sel_data), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_load(s_pc), .ifid_load(s_ifid), .idex_load(s_idex),
    .exmem_load(s_exmem), .memwb_load(s_memwb),
    .ifid_flush(s_iff), .idex_flush(s_idf),
    .mem_sel_data(s_sel), .halted(s_halted),
    .stall_cnt(s_stall), .flush_cnt(s_flush)
  );

  typedef struct {
    logic       memread;
    logic [4:0] rd, rs1, rs2;
    logic       br, mreq, mrdy;
    logic [4:0] loads;
    logic [1:0] fl;
    logic       sel;
    int         dstall, dflush;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [8:0] outs();
    return {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
            ifid_flush, idex_flush, mem_sel_data, halted};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic br, input logic mq, input logic my,
                       input logic hr);
    ex_memread = mr; ex_rd = rd; id_rs1 = r1; id_rs2 = r2;
    ex_branch_taken = br; mem_req = mq; mem_ready = my; halt_req = hr;
  endtask

  task automatic chk_cnt(input string name);
    chk({name, "_stall"}, stall_cnt, exp_stall);
    chk({name, "_flush"}, flush_cnt, exp_flush);
  endtask

  initial begin
    //        memrd rd rs1 rs2 br mreq mrdy loads   fl     sel ds df
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 0};
    tbl[1] = '{1, 5, 5, 0, 0, 0, 0, 5'b00111, 2'b01, 0, 1, 0};
    tbl[2] = '{1, 5, 0, 5, 0, 0, 0, 5'b00111, 2'b01, 0, 1, 0};
    tbl[3] = '{1, 0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 0};
    tbl[4] = '{0, 5, 5, 5, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 0, 1, 1, 5'b01111, 2'b10, 1, 1, 0};
    tbl[6] = '{1, 7, 3, 7, 0, 1, 1, 5'b00111, 2'b01, 1, 1, 0};
    tbl[7] = '{1, 5, 0, 5, 1, 0, 0, 5'b11111, 2'b11, 0, 0, 1};
    tbl[8] = '{0, 0, 0, 0, 1, 1, 1, 5'b11111, 2'b11, 1, 0, 1};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 1, 5'b11111, 2'b00, 0, 0, 0};

    // Outputs are forced low while reset is held
    #2;
    chk("reset_outs", {23'b0, outs()}, 32'h0);
    chk_cnt("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("freerun_outs", {23'b0, outs()}, {23'b0, 9'b11111_00_0_0});
      @(negedge clk);
    end
    chk_cnt("freerun");

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].memread, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
            tbl[i].br, tbl[i].mreq, tbl[i].mrdy, 0);
      #1;
      chk($sformatf("vec%0d_outs", i), {23'b0, outs()},
          {23'b0, tbl[i].loads, tbl[i].fl, tbl[i].sel, 1'b0});
      exp_stall += tbl[i].dstall;
      exp_flush += tbl[i].dflush;
      @(posedge clk);
      #1;
      chk_cnt($sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Memory wait: 3 cycles not ready, then release
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      #1;
      chk($sformatf("wait%0d_outs", i), {23'b0, outs()},
          {23'b0, 9'b00000_00_1_0});
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    #1;
    chk("release_outs", {23'b0, outs()}, {23'b0, 9'b01111_10_1_0});
    exp_stall += 4;
    @(posedge clk);
    #1;
    chk_cnt("wait");
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("after_wait_outs", {23'b0, outs()}, {23'b0, 9'b11111_00_0_0});
    @(negedge clk);

    // Halt: one drain cycle, then frozen
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("halt_req_outs", {23'b0, outs()}, {23'b0, 9'b00001_00_0_0});
    exp_stall += 1;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("halted%0d_outs", i), {23'b0, outs()},
          {23'b0, 9'b00000_00_0_1});
      @(negedge clk);
    end
    chk_cnt("halted");

    // Asynchronous reset mid-halt
    #2;
    rst = 1'b1;
    #1;
    chk("rst_halt_outs", {23'b0, outs()}, 32'h0);
    exp_stall = 0;
    exp_flush = 0;
    chk_cnt("rst_halt");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_outs", {23'b0, outs()}, {23'b0, 9'b11111_00_0_0});

    // Repeated load-use stalls saturate the 3-bit counter at 7
    drive(1, 9, 9, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      if (i == 6) chk("sat_reach", {29'b0, s_stall}, 32'd7);
    end
    chk("sat_hold", {29'b0, s_stall}, 32'd7);
    chk("sat_wide", stall_cnt, 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
